// File: rtl/alu_mdu_if.sv
// Request/response bus of alu_mdu: a valid/ready request channel carrying
// a MIPS instruction and two operands, and a valid/ready result channel.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;

  modport master (
    output in_valid, instruction, regA, regB, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, instruction, regA, regB, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_mdu.sv
// Multi-cycle MIPS ALU with an iterative HI/LO multiply/divide unit.
// Define ALU_MDU_DIV_EN to compile in the restoring divider (div/divu).
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  alu_mdu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE   = 6'h05,
                         OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D,
                         OP_XORI  = 6'h0E, OP_LW   = 6'h23, OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV  = 6'h07,
                         F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO  = 6'h12,
                         F_MTLO = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19,
                         F_DIV  = 6'h1A, F_DIVU = 6'h1B, F_ADD   = 6'h20,
                         F_ADDU = 6'h21, F_SUB  = 6'h22, F_SUBU  = 6'h23,
                         F_AND  = 6'h24, F_OR   = 6'h25, F_XOR   = 6'h26,
                         F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV, K_BAD} kind_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]       flags_q, flags_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, mc_q, mc_d;
  logic             neg_q, neg_d;

  // Instruction fields and operand selection
  logic [5:0]       opcode, funct;
  logic [4:0]       shamt;
  logic [15:0]      imm;
  logic [WIDTH-1:0] a, b, src, imm_s, imm_z;
  logic [SHW-1:0]   sh_imm, sh_var;
  logic             unused_fields;

  assign opcode = bus.instruction[31:26];
  assign funct  = bus.instruction[5:0];
  assign shamt  = bus.instruction[10:6];
  assign imm    = bus.instruction[15:0];
  assign a      = bus.regA;
  assign b      = bus.regB;
  assign src    = bus.instruction[21] ? b : a;
  assign imm_s  = WIDTH'($signed(imm));
  assign imm_z  = WIDTH'(imm);
  assign sh_imm = SHW'(shamt);
  assign sh_var = a[SHW-1:0];
  assign unused_fields = ^{bus.instruction[25:22], bus.instruction[20:16]};

  logic [WIDTH-1:0] sum_ab, diff_ab, sum_si;
  logic             ovf_add, ovf_sub, ovf_addi;

  assign sum_ab   = a + b;
  assign diff_ab  = a - b;
  assign sum_si   = src + imm_s;
  assign ovf_add  = (a[WIDTH-1] == b[WIDTH-1]) & (sum_ab[WIDTH-1] ^ a[WIDTH-1]);
  assign ovf_sub  = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff_ab[WIDTH-1] ^ a[WIDTH-1]);
  assign ovf_addi = (src[WIDTH-1] == imm_s[WIDTH-1]) & (sum_si[WIDTH-1] ^ src[WIDTH-1]);

  kind_e            kind;
  logic [WIDTH-1:0] alu_res;
  logic             alu_lt, alu_ovf, hi_we, lo_we;
  logic [2:0]       alu_flags;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    kind    = K_ALU;
    alu_res = '0;
    alu_lt  = 1'b0;
    alu_ovf = 1'b0;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL:  alu_res = b << sh_imm;
          F_SRL:  alu_res = b >> sh_imm;
          F_SRA:  alu_res = $signed(b) >>> sh_imm;
          F_SLLV: alu_res = b << sh_var;
          F_SRLV: alu_res = b >> sh_var;
          F_SRAV: alu_res = $signed(b) >>> sh_var;
          F_MFHI: alu_res = hi_q;
          F_MFLO: alu_res = lo_q;
          F_MTHI: begin alu_res = a; hi_we = 1'b1; end
          F_MTLO: begin alu_res = a; lo_we = 1'b1; end
          F_MULT, F_MULTU: kind = K_MUL;
          F_DIV, F_DIVU: begin
`ifdef ALU_MDU_DIV_EN
            kind = K_DIV;
`else
            kind = K_BAD;
`endif
          end
          F_ADD:  begin alu_res = sum_ab;  alu_ovf = ovf_add; end
          F_ADDU: alu_res = sum_ab;
          F_SUB:  begin alu_res = diff_ab; alu_ovf = ovf_sub; end
          F_SUBU: alu_res = diff_ab;
          F_AND:  alu_res = a & b;
          F_OR:   alu_res = a | b;
          F_XOR:  alu_res = a ^ b;
          F_NOR:  alu_res = ~(a | b);
          F_SLT:  begin alu_lt = $signed(a) < $signed(b); alu_res = WIDTH'(alu_lt); end
          F_SLTU: begin alu_lt = a < b;                   alu_res = WIDTH'(alu_lt); end
          default: kind = K_BAD;
        endcase
      end
      OP_BEQ, OP_BNE:       alu_res = diff_ab;
      OP_ADDI:              begin alu_res = sum_si; alu_ovf = ovf_addi; end
      OP_ADDIU, OP_LW, OP_SW: alu_res = sum_si;
      OP_SLTI:  begin alu_lt = $signed(src) < $signed(imm_s); alu_res = WIDTH'(alu_lt); end
      OP_SLTIU: begin alu_lt = src < imm_s;                   alu_res = WIDTH'(alu_lt); end
      OP_ANDI:  alu_res = src & imm_z;
      OP_ORI:   alu_res = src | imm_z;
      OP_XORI:  alu_res = src ^ imm_z;
      default:  kind = K_BAD;
    endcase
  end

  assign alu_flags = (kind == K_BAD) ? 3'b000 : {alu_res == '0, alu_lt, alu_ovf};

  // Signed mul/div run on magnitudes; the sign is restored at commit.
  logic             md_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign md_signed = ~funct[0];
  assign abs_a     = (md_signed & a[WIDTH-1]) ? -a : a;
  assign abs_b     = (md_signed & b[WIDTH-1]) ? -b : b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_acc, mul_mq;
  logic [2*WIDTH-1:0] prod_mag, prod_fin;

  assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mc_q} : '0);
  assign mul_acc  = mul_sum[WIDTH:1];
  assign mul_mq   = {mul_sum[0], mq_q[WIDTH-1:1]};
  assign prod_mag = {mul_acc, mul_mq};
  assign prod_fin = neg_q ? -prod_mag : prod_mag;

`ifdef ALU_MDU_DIV_EN
  logic             md_div_q, md_div_d, rneg_q, rneg_d, dz_q, dz_d, mn_q, mn_d;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc, div_mq;

  // With a zero divisor every step subtracts nothing, so HI ends up holding the dividend.
  assign div_sh  = {acc_q, mq_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, mc_q};
  assign div_acc = div_ge ? WIDTH'(div_sh - {1'b0, mc_q}) : div_sh[WIDTH-1:0];
  assign div_mq  = {mq_q[WIDTH-2:0], div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_div_q <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      mn_q     <= 1'b0;
    end else begin
      md_div_q <= md_div_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      mn_q     <= mn_d;
    end
  end
`endif

  logic [WIDTH-1:0] step_acc, step_mq, fin_hi, fin_lo;
  logic             fin_ovf;

  always_comb begin
    step_acc = mul_acc;
    step_mq  = mul_mq;
    fin_hi   = prod_fin[2*WIDTH-1:WIDTH];
    fin_lo   = prod_fin[WIDTH-1:0];
    fin_ovf  = 1'b0;
`ifdef ALU_MDU_DIV_EN
    if (md_div_q) begin
      step_acc = div_acc;
      step_mq  = div_mq;
      fin_hi   = rneg_q ? -div_acc : div_acc;
      fin_lo   = dz_q ? '1 : (neg_q ? -div_mq : div_mq);
      fin_ovf  = dz_q | mn_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flags_d = flags_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mc_d    = mc_q;
    neg_d   = neg_q;
`ifdef ALU_MDU_DIV_EN
    md_div_d = md_div_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    mn_d     = mn_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          acc_d = '0;
          mq_d  = abs_a;
          mc_d  = abs_b;
          cnt_d = '0;
          neg_d = md_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          case (kind)
            K_MUL: begin
              state_d = S_BUSY;
`ifdef ALU_MDU_DIV_EN
              md_div_d = 1'b0;
`endif
            end
`ifdef ALU_MDU_DIV_EN
            K_DIV: begin
              state_d  = S_BUSY;
              md_div_d = 1'b1;
              rneg_d   = md_signed & a[WIDTH-1];
              dz_d     = (b == '0);
              mn_d     = md_signed & (a == MIN_NEG) & (b == '1);
            end
`endif
            default: begin
              state_d = S_DONE;
              res_d   = alu_res;
              flags_d = alu_flags;
              if (hi_we) hi_d = a;
              if (lo_we) lo_d = a;
            end
          endcase
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          res_d   = fin_lo;
          flags_d = {fin_lo == '0, 1'b0, fin_ovf};
        end
      end
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      flags_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      mc_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mc_q    <= mc_d;
      neg_q   <= neg_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = res_q;
  assign bus.flags     = flags_q;
endmodule
